// File: rtl/exec_unit_md.sv
// exec_unit_md
//   Integer execution slot: single-cycle ALU and branch resolution plus an
//   iterative multiply/divide unit (shift-add MUL, restoring DIV/REM).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid, pc, ope, ds_val,     issue-slot instruction, sampled on
//   dt_val, dd, imm, opr, ctrl     accept = in_valid & ~busy
//   busy                           MD unit occupied, issue must hold
//   b_is_hazard, b_is_b_ope,       branch resolution flags, next PC and
//   b_is_branch, b_addr, b_w_pc    PC of the resolved instruction
//   alu_addr, alu_dd_val           single-cycle writeback (tag 0 = none)
//   md_valid, md_addr, md_dd_val   multiply/divide writeback pulse
module exec_unit_md #(
  parameter int XLEN     = 32,
  parameter int PC_W     = 14,
  parameter int TAG_W    = 6,
  parameter int LINK_TAG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   pc,
  input  logic [5:0]        ope,
  input  logic [XLEN-1:0]   ds_val,
  input  logic [XLEN-1:0]   dt_val,
  input  logic [TAG_W-1:0]  dd,
  input  logic [15:0]       imm,
  input  logic [4:0]        opr,
  input  logic [3:0]        ctrl,
  output logic              busy,
  output logic              b_is_hazard,
  output logic              b_is_b_ope,
  output logic              b_is_branch,
  output logic [PC_W-1:0]   b_addr,
  output logic [PC_W-1:0]   b_w_pc,
  output logic [TAG_W-1:0]  alu_addr,
  output logic [XLEN-1:0]   alu_dd_val,
  output logic              md_valid,
  output logic [TAG_W-1:0]  md_addr,
  output logic [XLEN-1:0]   md_dd_val
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] MD_MUL = 2'd0;
  localparam logic [1:0] MD_DIV = 2'd1;
  localparam logic [1:0] MD_REM = 2'd2;

  // ---------------- single-cycle decode ----------------
  logic             accept;
  logic [XLEN-1:0]  imm_sx, opr_sx, op2, alu_res, lui_val;
  logic [SH_W-1:0]  shamt;
  logic [PC_W-1:0]  pc_inc, b_addr_d;
  logic             wr_dd, wr_link, is_br, is_jr, taken, is_md, hazard_d;
  logic [1:0]       md_sel;
  logic             unused_ctrl;

  assign unused_ctrl = ^ctrl[3:1];
  assign accept = in_valid & ~busy;
  assign imm_sx = XLEN'($signed(imm));
  assign opr_sx = XLEN'($signed(opr));
  assign op2    = ope[2] ? dt_val : imm_sx;
  assign shamt  = op2[SH_W-1:0];
  assign pc_inc = pc + PC_W'(1);

  // LUI keeps the low XLEN-16 bits of ds; at XLEN=16 nothing remains.
  generate
    if (XLEN > 16) begin : g_lui_wide
      assign lui_val = {imm, ds_val[XLEN-17:0]};
    end else begin : g_lui_narrow
      assign lui_val = imm;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    wr_dd   = 1'b0;
    wr_link = 1'b0;
    is_br   = 1'b0;
    is_jr   = 1'b0;
    taken   = 1'b0;
    is_md   = 1'b0;
    md_sel  = MD_MUL;
    case (ope)
      6'b110000: begin alu_res = lui_val;                     wr_dd = 1'b1; end
      6'b001100,
      6'b001000: begin alu_res = ds_val + op2;                wr_dd = 1'b1; end
      6'b010100: begin alu_res = ds_val - op2;                wr_dd = 1'b1; end
      6'b011100,
      6'b011000: begin alu_res = ds_val << shamt;             wr_dd = 1'b1; end
      6'b100100,
      6'b100000: begin alu_res = ds_val >> shamt;             wr_dd = 1'b1; end
      6'b101100,
      6'b101000: begin alu_res = $signed(ds_val) >>> shamt;   wr_dd = 1'b1; end
      6'b000010: taken = 1'b1;
      6'b000110: begin taken = 1'b1; wr_link = 1'b1; end
      6'b001010: begin taken = 1'b1; is_jr = 1'b1; end
      6'b001110: begin taken = 1'b1; is_jr = 1'b1; wr_link = 1'b1; end
      6'b010010: begin is_br = 1'b1; taken = (ds_val == dt_val); end
      6'b011010: begin is_br = 1'b1; taken = ($signed(ds_val) <= $signed(dt_val)); end
      6'b110010: begin is_br = 1'b1; taken = (ds_val == opr_sx); end
      6'b111010: begin is_br = 1'b1; taken = (ds_val != opr_sx); end
      6'b100010: begin is_br = 1'b1; taken = ($signed(ds_val) <= $signed(opr_sx)); end
      6'b101010: begin is_br = 1'b1; taken = ($signed(ds_val) >= $signed(opr_sx)); end
      6'b110100: begin is_md = 1'b1; md_sel = MD_MUL; end
      6'b111100: begin is_md = 1'b1; md_sel = MD_DIV; end
      6'b111000: begin is_md = 1'b1; md_sel = MD_REM; end
      default: ;
    endcase
    if (wr_link) alu_res = XLEN'(pc_inc);
  end

  assign hazard_d = is_jr | (is_br & (taken ^ ctrl[0]));
  assign b_addr_d = is_jr ? ds_val[PC_W-1:0] : (taken ? imm[PC_W-1:0] : pc_inc);

  logic             hazard_q, b_ope_q, branch_q;
  logic [PC_W-1:0]  b_addr_q, b_w_pc_q;
  logic [TAG_W-1:0] alu_addr_q;
  logic [XLEN-1:0]  alu_val_q;

  // Flags and tag clear every cycle without an accept; data fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_q   <= 1'b0;
      b_ope_q    <= 1'b0;
      branch_q   <= 1'b0;
      b_addr_q   <= '0;
      b_w_pc_q   <= '0;
      alu_addr_q <= '0;
      alu_val_q  <= '0;
    end else begin
      hazard_q   <= 1'b0;
      b_ope_q    <= 1'b0;
      branch_q   <= 1'b0;
      alu_addr_q <= '0;
      if (accept) begin
        hazard_q   <= hazard_d;
        b_ope_q    <= is_br;
        branch_q   <= taken;
        b_addr_q   <= b_addr_d;
        b_w_pc_q   <= pc;
        alu_val_q  <= alu_res;
        alu_addr_q <= wr_dd ? dd : (wr_link ? TAG_W'(LINK_TAG) : '0);
      end
    end
  end

  // ---------------- iterative multiply / divide ----------------
  // MUL:     acc += a if b[0]; a <<= 1; b >>= 1
  // DIV/REM: acc = partial remainder, a = dividend shifting into quotient,
  //          b = divisor magnitude
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       md_op_q, md_op_d;
  logic [XLEN-1:0]  acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic             negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             mdv_q, mdv_d;
  logic [TAG_W-1:0] mda_q, mda_d;
  logic [XLEN-1:0]  mdr_q, mdr_d;

  logic [XLEN:0]    shifted, diff;
  logic             ge;
  logic [XLEN-1:0]  rem_step, quo_step, mul_step, md_res, ds_abs, dt_abs;

  assign shifted  = {acc_q, a_q[XLEN-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign ge       = ~diff[XLEN];
  assign rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_step = {a_q[XLEN-2:0], ge};
  assign mul_step = acc_q + (b_q[0] ? a_q : '0);
  assign ds_abs   = ds_val[XLEN-1] ? -ds_val : ds_val;
  assign dt_abs   = dt_val[XLEN-1] ? -dt_val : dt_val;

  // Result of the final iteration with the sign correction applied.
  // Divide by zero yields an all-ones quotient magnitude naturally, but the
  // sign fix would disturb it, so it is forced.
  always_comb begin
    case (md_op_q)
      MD_MUL:  md_res = mul_step;
      MD_DIV:  md_res = div0_q ? '1 : (negq_q ? -quo_step : quo_step);
      default: md_res = negr_q ? -rem_step : rem_step;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    tag_d   = tag_q;
    mdv_d   = 1'b0;
    mda_d   = mda_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_md) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(XLEN);
          md_op_d = md_sel;
          acc_d   = '0;
          a_d     = (md_sel == MD_MUL) ? ds_val : ds_abs;
          b_d     = (md_sel == MD_MUL) ? dt_val : dt_abs;
          negq_d  = ds_val[XLEN-1] ^ dt_val[XLEN-1];
          negr_d  = ds_val[XLEN-1];
          div0_d  = (dt_val == '0);
          tag_d   = dd;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (md_op_q == MD_MUL) begin
          acc_d = mul_step;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = rem_step;
          a_d   = quo_step;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          mdv_d   = 1'b1;
          mda_d   = tag_q;
          mdr_d   = md_res;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_op_q <= MD_MUL;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      tag_q   <= '0;
      mdv_q   <= 1'b0;
      mda_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      tag_q   <= tag_d;
      mdv_q   <= mdv_d;
      mda_q   <= mda_d;
      mdr_q   <= mdr_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign b_is_hazard = hazard_q;
  assign b_is_b_ope  = b_ope_q;
  assign b_is_branch = branch_q;
  assign b_addr      = b_addr_q;
  assign b_w_pc      = b_w_pc_q;
  assign alu_addr    = alu_addr_q;
  assign alu_dd_val  = alu_val_q;
  assign md_valid    = mdv_q;
  assign md_addr     = mda_q;
  assign md_dd_val   = mdr_q;

endmodule

// File: tb/tb_exec_unit_md.sv
module tb_exec_unit_md;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic        in_valid = 1'b0;
  logic [13:0] pc = '0;
  logic [5:0]  ope = '0;
  logic [31:0] ds_val = '0, dt_val = '0;
  logic [5:0]  dd = '0;
  logic [15:0] imm = '0;
  logic [4:0]  opr = '0;
  logic [3:0]  ctrl = '0;
  logic        busy, b_is_hazard, b_is_b_ope, b_is_branch, md_valid;
  logic [13:0] b_addr, b_w_pc;
  logic [5:0]  alu_addr, md_addr;
  logic [31:0] alu_dd_val, md_dd_val;

  // narrow instance, XLEN=16, PC_W=12
  logic        s_in_valid = 1'b0;
  logic [11:0] s_pc = '0;
  logic [5:0]  s_ope = '0;
  logic [15:0] s_ds_val = '0, s_dt_val = '0;
  logic [5:0]  s_dd = '0;
  logic [15:0] s_imm = '0;
  logic [4:0]  s_opr = '0;
  logic [3:0]  s_ctrl = '0;
  logic        s_busy, s_b_is_hazard, s_b_is_b_ope, s_b_is_branch, s_md_valid;
  logic [11:0] s_b_addr, s_b_w_pc;
  logic [5:0]  s_alu_addr, s_md_addr;
  logic [15:0] s_alu_dd_val, s_md_dd_val;

  exec_unit_md dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc(pc), .ope(ope),
    .ds_val(ds_val), .dt_val(dt_val), .dd(dd), .imm(imm), .opr(opr), .ctrl(ctrl),
    .busy(busy), .b_is_hazard(b_is_hazard), .b_is_b_ope(b_is_b_ope),
    .b_is_branch(b_is_branch), .b_addr(b_addr), .b_w_pc(b_w_pc),
    .alu_addr(alu_addr), .alu_dd_val(alu_dd_val), .md_valid(md_valid),
    .md_addr(md_addr), .md_dd_val(md_dd_val));

  exec_unit_md #(.XLEN(16), .PC_W(12), .TAG_W(6), .LINK_TAG(31)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .pc(s_pc), .ope(s_ope),
    .ds_val(s_ds_val), .dt_val(s_dt_val), .dd(s_dd), .imm(s_imm), .opr(s_opr), .ctrl(s_ctrl),
    .busy(s_busy), .b_is_hazard(s_b_is_hazard), .b_is_b_ope(s_b_is_b_ope),
    .b_is_branch(s_b_is_branch), .b_addr(s_b_addr), .b_w_pc(s_b_w_pc),
    .alu_addr(s_alu_addr), .alu_dd_val(s_alu_dd_val), .md_valid(s_md_valid),
    .md_addr(s_md_addr), .md_dd_val(s_md_dd_val));

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] OP_TAB [26] = '{
    6'b110000, 6'b001100, 6'b001000, 6'b010100, 6'b011100, 6'b011000,
    6'b100100, 6'b100000, 6'b101100, 6'b101000, 6'b000010, 6'b000110,
    6'b001010, 6'b001110, 6'b010010, 6'b011010, 6'b110010, 6'b111010,
    6'b100010, 6'b101010, 6'b110100, 6'b111100, 6'b111000,
    6'b000000, 6'b111111, 6'b010110};

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] val;
    logic        is_b, haz, br, chk_br, chk_addr;
    logic [13:0] baddr;
  } exp_t;

  function automatic logic is_md_op(input logic [5:0] o);
    return (o == 6'b110100) || (o == 6'b111100) || (o == 6'b111000);
  endfunction

  // Expected single-cycle result straight from the opcode table.
  function automatic exp_t model_sc(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [5:0] tag, input logic [13:0] p, input logic [15:0] im,
                                    input logic [4:0] op_r, input logic c0);
    exp_t e;
    longint sa, sb, so, si;
    logic [31:0] op2;
    int sh;
    logic t;
    sa = $signed(a); sb = $signed(b); so = $signed(op_r); si = $signed(im);
    op2 = o[2] ? b : 32'(si);
    sh = int'(op2[4:0]);
    e = '0;
    t = 1'b0;
    case (o)
      6'b110000: begin e.addr = tag; e.val = {im, a[15:0]}; end
      6'b001100, 6'b001000: begin e.addr = tag; e.val = a + op2; end
      6'b010100: begin e.addr = tag; e.val = a - op2; end
      6'b011100, 6'b011000: begin e.addr = tag; e.val = a << sh; end
      6'b100100, 6'b100000: begin e.addr = tag; e.val = a >> sh; end
      6'b101100, 6'b101000: begin e.addr = tag; e.val = 32'(sa >>> sh); end
      6'b000110: begin e.addr = 6'd31; e.val = {18'b0, p + 14'd1}; end
      6'b001010: begin e.haz = 1'b1; e.chk_addr = 1'b1; e.baddr = a[13:0]; end
      6'b001110: begin e.haz = 1'b1; e.chk_addr = 1'b1; e.baddr = a[13:0];
                       e.addr = 6'd31; e.val = {18'b0, p + 14'd1}; end
      6'b010010, 6'b011010, 6'b110010, 6'b111010, 6'b100010, 6'b101010: begin
        case (o)
          6'b010010: t = (sa == sb);
          6'b011010: t = (sa <= sb);
          6'b110010: t = (sa == so);
          6'b111010: t = (sa != so);
          6'b100010: t = (sa <= so);
          default:   t = (sa >= so);
        endcase
        e.is_b = 1'b1; e.br = t; e.haz = t ^ c0; e.chk_br = 1'b1; e.chk_addr = 1'b1;
        e.baddr = t ? im[13:0] : p + 14'd1;
      end
      6'b000010: ;
      default: e.chk_br = 1'b1;  // unlisted or MD: no branch
    endcase
    return e;
  endfunction

  function automatic logic [31:0] model_md(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a); sb = $signed(b);
    if (o == 6'b110100) return 32'(sa * sb);
    if (o == 6'b111100) return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
    return (b == 0) ? a : 32'(sa % sb);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                       input logic [13:0] p, input logic [15:0] im, input logic [4:0] op_r, input logic c0);
    in_valid = 1'b1; ope = o; ds_val = a; dt_val = b; dd = tag; pc = p; imm = im; opr = op_r;
    ctrl = {3'b101, c0};
  endtask

  // Issue one MD op, watch busy/md_valid timing and the result.
  task automatic test_md_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    logic [31:0] exp_v;
    int n;
    logic early;
    exp_v = model_md(o, a, b);
    drive(o, a, b, tag, 14'h10, 16'h0, 5'h0, 1'b0);
    step;
    in_valid = 1'b0;
    n = 0; early = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (md_valid !== 1'b0 || alu_addr !== 6'd0) early = 1'b1;
      n++;
      step;
    end
    n_checks++; if (n != 32) begin n_fail++; $display("FAIL md_latency op=%b got=%0d exp=32", o, n); end
    n_checks++; if (early) begin n_fail++; $display("FAIL md_quiet_in_run op=%b got=1 exp=0", o); end
    n_checks++; if (md_valid !== 1'b1) begin n_fail++; $display("FAIL md_valid op=%b got=%b exp=1", o, md_valid); end
    n_checks++; if (md_addr !== tag) begin n_fail++; $display("FAIL md_addr op=%b got=%h exp=%h", o, md_addr, tag); end
    n_checks++; if (md_dd_val !== exp_v) begin n_fail++; $display("FAIL md_val op=%b a=%h b=%h got=%h exp=%h", o, a, b, md_dd_val, exp_v); end
    step;
    n_checks++; if (md_valid !== 1'b0 || md_dd_val !== exp_v) begin n_fail++;
      $display("FAIL md_pulse_hold op=%b got=%b/%h exp=0/%h", o, md_valid, md_dd_val, exp_v); end
    $display("txn md op=%b a=%h b=%h tag=%0d res=%h cycles=%0d", o, a, b, tag, md_dd_val, n);
  endtask

  task automatic test_reset;
    step; step;
    n_checks++; if ({busy, b_is_hazard, b_is_b_ope, b_is_branch, md_valid} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=0", {busy, b_is_hazard, b_is_b_ope, b_is_branch, md_valid}); end
    n_checks++; if ({b_addr, b_w_pc, alu_addr, alu_dd_val, md_addr, md_dd_val} !== '0) begin n_fail++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h/%h exp=0", b_addr, b_w_pc, alu_addr, alu_dd_val, md_addr, md_dd_val); end
    rst = 1'b0;
    drive(6'b001000, 32'd5, 32'd0, 6'd7, 14'h20, 16'hFFFF, 5'd0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if (alu_addr !== 6'd7 || alu_dd_val !== 32'd4) begin n_fail++;
      $display("FAIL addi got=%h/%h exp=07/00000004", alu_addr, alu_dd_val); end
    $display("txn addi ds=5 imm=ffff tag=%0d res=%h", alu_addr, alu_dd_val);
    // mid-cycle reset clears outputs immediately
    drive(6'b001010, 32'h3FFF, 32'd0, 6'd3, 14'h155, 16'h0, 5'd0, 1'b0);
    step;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({b_is_hazard, b_is_branch, b_addr, b_w_pc, alu_addr, alu_dd_val} !== '0) begin n_fail++;
      $display("FAIL async_reset got=%b%b/%h/%h/%h/%h exp=0", b_is_hazard, b_is_branch, b_addr, b_w_pc, alu_addr, alu_dd_val); end
    @(negedge clk) rst = 1'b0;
    step;
  endtask

  task automatic test_branches;
    drive(6'b110010, 32'd3, 32'd0, 6'd0, 14'h100, 16'h0ABC, 5'd3, 1'b0);
    step;
    n_checks++; if ({b_is_branch, b_is_hazard, b_is_b_ope} !== 3'b111 || b_addr !== 14'h0ABC || b_w_pc !== 14'h100) begin n_fail++;
      $display("FAIL beqi got=%b%b%b/%h/%h exp=111/0abc/0100", b_is_branch, b_is_hazard, b_is_b_ope, b_addr, b_w_pc); end
    $display("txn beqi taken=%b haz=%b addr=%h", b_is_branch, b_is_hazard, b_addr);
    drive(6'b101010, 32'hFFFF_FFFF, 32'd0, 6'd0, 14'h200, 16'h0777, 5'd0, 1'b0);
    step;
    n_checks++; if ({b_is_branch, b_is_hazard, b_is_b_ope} !== 3'b001 || b_addr !== 14'h201) begin n_fail++;
      $display("FAIL bgei got=%b%b%b/%h exp=001/0201", b_is_branch, b_is_hazard, b_is_b_ope, b_addr); end
    $display("txn bgei taken=%b haz=%b addr=%h", b_is_branch, b_is_hazard, b_addr);
    drive(6'b001010, 32'h123, 32'd0, 6'd9, 14'h300, 16'h0555, 5'd0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if (b_is_hazard !== 1'b1 || b_addr !== 14'h123 || alu_addr !== 6'd0 || b_is_b_ope !== 1'b0) begin n_fail++;
      $display("FAIL jr got=%b/%h/%h/%b exp=1/0123/00/0", b_is_hazard, b_addr, alu_addr, b_is_b_ope); end
    $display("txn jr haz=%b addr=%h", b_is_hazard, b_addr);
    step;
  endtask

  task automatic test_divrem;
    test_md_op(6'b110100, -32'sd7, 32'd6, 6'd4);
    test_md_op(6'b111100, -32'sd7, 32'd2, 6'd5);
    test_md_op(6'b111000, -32'sd7, 32'd2, 6'd6);
    test_md_op(6'b111100, 32'd5, 32'd0, 6'd7);
    test_md_op(6'b111000, 32'd5, 32'd0, 6'd8);
    test_md_op(6'b111100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9);
    test_md_op(6'b111000, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0);
    // independent constants for the headline cases
    test_md_op(6'b110100, 32'd0, 32'hFFFF_FFFF, 6'd1);
  endtask

  task automatic test_hold_during_busy;
    int n;
    logic leak;
    drive(6'b110100, -32'sd7, 32'd6, 6'd9, 14'h40, 16'h0, 5'd0, 1'b0);
    step;
    drive(6'b001100, 32'd10, 32'd20, 6'd12, 14'h41, 16'h0, 5'd0, 1'b0);
    n = 0; leak = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (alu_addr !== 6'd0) leak = 1'b1;
      n++;
      step;
    end
    n_checks++; if (leak) begin n_fail++; $display("FAIL hold_accept_early got=1 exp=0"); end
    n_checks++; if (md_valid !== 1'b1 || md_dd_val !== 32'hFFFF_FFD6) begin n_fail++;
      $display("FAIL hold_mul got=%b/%h exp=1/ffffffd6", md_valid, md_dd_val); end
    step;
    in_valid = 1'b0;
    n_checks++; if (alu_addr !== 6'd12 || alu_dd_val !== 32'd30) begin n_fail++;
      $display("FAIL hold_add got=%h/%h exp=0c/0000001e", alu_addr, alu_dd_val); end
    $display("txn held add tag=%0d res=%h after %0d busy cycles", alu_addr, alu_dd_val, n);
    step;
    n_checks++; if (alu_addr !== 6'd0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL hold_single got=%h/%b exp=00/0", alu_addr, busy); end
  endtask

  task automatic test_reset_md;
    logic seen;
    drive(6'b111100, 32'd100, 32'd7, 6'd5, 14'h50, 16'h0, 5'd0, 1'b0);
    step;
    in_valid = 1'b0;
    repeat (22) step;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || md_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_md got=%b/%b exp=0/0", busy, md_valid); end
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin step; if (md_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_md_ghost got=1 exp=0"); end
    drive(6'b001100, 32'd1000, 32'd234, 6'd33, 14'h60, 16'h0, 5'd0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if (alu_addr !== 6'd33 || alu_dd_val !== 32'd1234) begin n_fail++;
      $display("FAIL rst_md_add got=%h/%h exp=21/000004d2", alu_addr, alu_dd_val); end
    $display("txn add after abort tag=%0d res=%h", alu_addr, alu_dd_val);
    step;
  endtask

  task automatic test_random;
    logic [5:0]  o, tag;
    logic [31:0] a, b;
    logic [13:0] p;
    logic [15:0] im;
    logic [4:0]  op_r;
    logic        c0;
    exp_t        e;
    for (int i = 0; i < 60; i++) begin
      o = OP_TAB[$urandom_range(0, 25)];
      a = $urandom; b = $urandom; tag = 6'($urandom); p = 14'($urandom);
      im = 16'($urandom); op_r = 5'($urandom); c0 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {{27{op_r[4]}}, op_r};
      if (is_md_op(o)) begin
        test_md_op(o, a, b, tag);
      end else begin
        e = model_sc(o, a, b, tag, p, im, op_r, c0);
        drive(o, a, b, tag, p, im, op_r, c0);
        step;
        n_checks++; if (alu_addr !== e.addr) begin n_fail++;
          $display("FAIL rnd_addr op=%b got=%h exp=%h", o, alu_addr, e.addr); end
        if (e.addr != 6'd0) begin
          n_checks++; if (alu_dd_val !== e.val) begin n_fail++;
            $display("FAIL rnd_val op=%b a=%h b=%h im=%h got=%h exp=%h", o, a, b, im, alu_dd_val, e.val); end
        end
        n_checks++; if (b_is_b_ope !== e.is_b || b_is_hazard !== e.haz || b_w_pc !== p) begin n_fail++;
          $display("FAIL rnd_flags op=%b got=%b%b/%h exp=%b%b/%h", o, b_is_b_ope, b_is_hazard, b_w_pc, e.is_b, e.haz, p); end
        if (e.chk_br) begin
          n_checks++; if (b_is_branch !== e.br) begin n_fail++;
            $display("FAIL rnd_taken op=%b got=%b exp=%b", o, b_is_branch, e.br); end
        end
        if (e.chk_addr) begin
          n_checks++; if (b_addr !== e.baddr) begin n_fail++;
            $display("FAIL rnd_baddr op=%b got=%h exp=%h", o, b_addr, e.baddr); end
        end
        $display("txn rnd op=%b a=%h b=%h tag=%0d res=%h br=%b", o, a, b, alu_addr, alu_dd_val, b_is_branch);
      end
    end
    in_valid = 1'b0;
    step;
    n_checks++; if (alu_addr !== 6'd0 || b_is_b_ope !== 1'b0 || b_is_hazard !== 1'b0) begin n_fail++;
      $display("FAIL idle_clear got=%h/%b/%b exp=00/0/0", alu_addr, b_is_b_ope, b_is_hazard); end
  endtask

  task automatic test_param_sweep;
    int n;
    s_in_valid = 1'b1; s_ope = 6'b101100; s_ds_val = 16'h8000; s_dt_val = 16'd15; s_dd = 6'd3; s_pc = 12'h10;
    step;
    n_checks++; if (s_alu_addr !== 6'd3 || s_alu_dd_val !== 16'hFFFF) begin n_fail++;
      $display("FAIL s_sra got=%h/%h exp=03/ffff", s_alu_addr, s_alu_dd_val); end
    $display("txn s_sra res=%h", s_alu_dd_val);
    s_ope = 6'b000110; s_pc = 12'h123; s_dd = 6'd5;
    step;
    n_checks++; if (s_alu_addr !== 6'd31 || s_alu_dd_val !== 16'h0124) begin n_fail++;
      $display("FAIL s_jal got=%h/%h exp=1f/0124", s_alu_addr, s_alu_dd_val); end
    $display("txn s_jal tag=%0d res=%h", s_alu_addr, s_alu_dd_val);
    s_ope = 6'b110100; s_ds_val = 16'd3; s_dt_val = 16'hFFFB; s_dd = 6'd2;
    step;
    s_in_valid = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin n++; step; end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL s_mul_latency got=%0d exp=16", n); end
    n_checks++; if (s_md_valid !== 1'b1 || s_md_dd_val !== 16'hFFF1 || s_md_addr !== 6'd2) begin n_fail++;
      $display("FAIL s_mul got=%b/%h/%h exp=1/fff1/02", s_md_valid, s_md_dd_val, s_md_addr); end
    $display("txn s_mul res=%h cycles=%0d", s_md_dd_val, n);
    step;
  endtask

  initial begin
    test_reset;
    test_branches;
    test_divrem;
    test_hold_during_busy;
    test_reset_md;
    test_random;
    test_param_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
